// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, reads instruction words
// over a req/ack handshake, holds the fetched word for decode until it retires,
// then advances sequentially or to a branch target. A retired HALT opcode
// parks the stage until reset.
//
// Handshake: imem_req is high for every cycle the stage sits in FETCH, with
// imem_addr = pc held stable. A cycle with imem_req=1 and imem_ack=1 transfers
// imem_rdata; imem_ack in any other cycle is ignored. Toward decode,
// instr_valid=1 offers instr, and the instruction retires on any edge where
// instr_valid=1 and stall=0.
module instr_fetch #(
    parameter int          ADDR_W   = 8,
    parameter int          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]  HALT_OP  = 4'b1111
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         OPCODE,
    output logic               instr_valid,
    output logic               halted,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;

    // Request and address come straight from registered state and pc, so no
    // input reaches an output combinationally.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign OPCODE    = instr[INSTR_W-1 -: 4];
    assign state_dbg = state;

    // Fetch/issue/halt sequencing with all datapath registers updated alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A stalled cycle holds everything; branch inputs only
                    // matter on the retire edge.
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (instr[INSTR_W-1 -: 4] == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc    <= branch_en ? branch_target : pc + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
